// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Drives the datapath selects and enables from the current state, and talks to a shared memory port through mem_req/mem_ready.
// Optional: define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters (CNT_W bits wide).
module multicycle_controller
`ifdef MC_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t state;
    state_t state_next;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    // Next-state and Moore output decode; memory strobes are qualified by mem_ready
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WD;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;

        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = op[5] ? IMM_S : IMM_I;
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = mem_ready;
                if (mem_ready) state_next = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = (state == EXECI) ? SRCB_IMM : SRCB_WD;
                state_next = ALUWB;
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: state_next = TRAP;
                endcase
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRCA_A;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
                state_next = FETCH;
            end
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = ALUWB;
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // No memory access or architectural update while held in reset
        if (!reset) begin
            mem_req  = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // Sticky flag raised when the FSM enters TRAP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  illegal <= 1'b0;
        else if (state_next == TRAP) illegal <= 1'b1;
    end

`ifdef MC_PERF_CNT_EN
    logic retire_c;

    // An instruction retires on the exit edge of its final state
    always_comb begin
        retire_c = 1'b0;
        case (state)
            MEMWB, ALUWB, BEQ: retire_c = 1'b1;
            MEMWRITE:          retire_c = mem_ready;
            default:           retire_c = 1'b0;
        endcase
    end

    // Free-running cycle and retired-instruction counters, wrapping at 2^CNT_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire_c) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
